// File: rtl/ama_mon_pkg.sv
// -----------------------------------------------------------------------------
// ama_mon_pkg
// Shared definitions for the approximate-adder error monitor family:
//   - default WIDTH / CNT_W / ACC_W constants
//   - run-state enum (IDLE, RUN, DONE)
//   - sat_add(): saturating unsigned add on a wide container, clipped to a
//     caller-supplied width, so every accumulator width uses the same helper.
// -----------------------------------------------------------------------------
package ama_mon_pkg;

  localparam int DEF_WIDTH = 24;
  localparam int DEF_CNT_W = 32;
  localparam int DEF_ACC_W = 48;

  // Container width for sat_add; must exceed every accumulator that uses it.
  localparam int SAT_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returns min(acc + inc, 2^width - 1). acc is assumed already <= the limit.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] acc,
                                               input logic [SAT_W-1:0] inc,
                                               input int unsigned      width);
    logic [SAT_W:0]   sum;
    logic [SAT_W-1:0] limit;
    limit = (width >= SAT_W) ? '1 : ((SAT_W'(1) << width) - SAT_W'(1));
    sum   = {1'b0, acc} + {1'b0, inc};
    if (sum > {1'b0, limit}) return limit;
    else                     return sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/ama_error_monitor_if.sv
// -----------------------------------------------------------------------------
// ama_error_monitor_if
// Tuple stream from the adder under test into the error monitor.
//   in_valid  : tuple present (master -> slave)
//   in_ready  : monitor accepts this cycle (slave -> master)
//   a, b, cin : operands fed to the adder under test
//   appr_sum, appr_cout : approximate result produced by that adder
// A tuple transfers on a rising edge where in_valid && in_ready.
// -----------------------------------------------------------------------------
interface ama_error_monitor_if
  import ama_mon_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] appr_sum;
  logic             appr_cout;

  modport master (
    output in_valid, a, b, cin, appr_sum, appr_cout,
    input  in_ready
  );

  modport slave (
    input  in_valid, a, b, cin, appr_sum, appr_cout,
    output in_ready
  );
endinterface

// File: rtl/ama_error_monitor_ed_calc.sv
// -----------------------------------------------------------------------------
// ama_ed_calc
// Pure combinational exact-sum and absolute-difference unit. The two halves
// are independent so a pipelined user can compute the exact value in one
// stage and the distance in the next.
//   i_a, i_b, i_cin : operands            -> o_exact = i_a + i_b + i_cin
//   i_x, i_y        : WIDTH+1-bit values  -> o_diff  = |i_x - i_y|
// -----------------------------------------------------------------------------
module ama_ed_calc
  import ama_mon_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH:0]   o_exact,
  input  logic [WIDTH:0]   i_x,
  input  logic [WIDTH:0]   i_y,
  output logic [WIDTH:0]   o_diff
);

  // NOTE: every output of a combinational block is assigned on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    o_exact = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
    o_diff  = '0;
    if (i_x >= i_y) o_diff = i_x - i_y;
    else            o_diff = i_y - i_x;
  end

endmodule

// File: rtl/ama_error_monitor.sv
// -----------------------------------------------------------------------------
// ama_error_monitor
// Streaming error-characterization monitor for approximate multi-bit adders.
// Each accepted tuple's exact sum is compared against the adder's approximate
// {cout, sum}; the error distance feeds run statistics over n_samples tuples.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : pulse - clear statistics, latch n_samples, begin a run
//                   (ignored while a run is in progress)
//   clear         : synchronous abort to IDLE, wins over start
//   n_samples     : samples per run
//   in_if         : tuple stream (slave side)
//   busy / done   : state is RUN / state is DONE
//   sample_count  : samples accumulated
//   err_count     : samples with nonzero error distance
//   max_ed        : largest error distance
//   sum_ed        : saturating sum of error distances
//   last_ed       : error distance of the most recent sample
//   sum_sq_ed     : saturating sum of ed*ed (only with AMA_MON_SQERR_EN)
//
// Build option: define AMA_MON_SQERR_EN to add the sum_sq_ed output and its
// stage-2 multiplier.
//
// Pipeline: edge k registers exact/approx for an accepted tuple; edge k+1
// registers the distance into the statistics. The FSM leaves RUN on the same
// edge that the final sample lands in the statistics.
// -----------------------------------------------------------------------------
module ama_error_monitor
  import ama_mon_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  clear,
  input  logic [CNT_W-1:0]      n_samples,
  ama_error_monitor_if.slave    in_if,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      sample_count,
  output logic [CNT_W-1:0]      err_count,
  output logic [WIDTH:0]        max_ed,
  output logic [ACC_W-1:0]      sum_ed,
  output logic [WIDTH:0]        last_ed
`ifdef AMA_MON_SQERR_EN
  ,
  output logic [2*WIDTH+17:0]   sum_sq_ed
`endif
);

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic               r_in_ready;
  logic [CNT_W-1:0]   r_target;
  logic [CNT_W-1:0]   r_accepted;

  logic               r_s1_valid;
  logic [WIDTH:0]     r_s1_exact;
  logic [WIDTH:0]     r_s1_approx;

  logic [CNT_W-1:0]   r_sample_count;
  logic [CNT_W-1:0]   r_err_count;
  logic [WIDTH:0]     r_max_ed;
  logic [ACC_W-1:0]   r_sum_ed;
  logic [WIDTH:0]     r_last_ed;

  logic               w_xfer;
  logic [WIDTH:0]     w_exact;
  logic [WIDTH:0]     w_ed;

  assign w_xfer         = in_if.in_valid && r_in_ready;
  assign in_if.in_ready = r_in_ready;

  // Exact sum uses the live operands (stage 1); distance uses the stage-1
  // registers (stage 2).
  ama_ed_calc #(
    .WIDTH (WIDTH)
  ) u_ed_calc (
    .i_a     (in_if.a),
    .i_b     (in_if.b),
    .i_cin   (in_if.cin),
    .o_exact (w_exact),
    .i_x     (r_s1_exact),
    .i_y     (r_s1_approx),
    .o_diff  (w_ed)
  );

`ifdef AMA_MON_SQERR_EN
  localparam int SQ_W = 2*WIDTH + 18;

  logic [SQ_W-1:0]      r_sum_sq_ed;
  logic [2*WIDTH+1:0]   w_ed_sq;

  assign w_ed_sq = {{(WIDTH+1){1'b0}}, w_ed} * {{(WIDTH+1){1'b0}}, w_ed};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum_sq_ed <= '0;
    end else if (clear) begin
      r_sum_sq_ed <= '0;
    end else if (start && (r_state != RUN)) begin
      r_sum_sq_ed <= '0;
    end else if (r_s1_valid) begin
      r_sum_sq_ed <= SQ_W'(sat_add(SAT_W'(r_sum_sq_ed), SAT_W'(w_ed_sq), SQ_W));
    end
  end

  assign sum_sq_ed = r_sum_sq_ed;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order; later
  // statements in this block simply override earlier ones (start/clear win).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_in_ready     <= 1'b0;
      r_target       <= '0;
      r_accepted     <= '0;
      r_s1_valid     <= 1'b0;
      r_s1_exact     <= '0;
      r_s1_approx    <= '0;
      r_sample_count <= '0;
      r_err_count    <= '0;
      r_max_ed       <= '0;
      r_sum_ed       <= '0;
      r_last_ed      <= '0;
    end else if (clear) begin
      // Abort: drop any stage-1 sample and zero the statistics.
      r_state        <= IDLE;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_in_ready     <= 1'b0;
      r_accepted     <= '0;
      r_s1_valid     <= 1'b0;
      r_sample_count <= '0;
      r_err_count    <= '0;
      r_max_ed       <= '0;
      r_sum_ed       <= '0;
      r_last_ed      <= '0;
    end else begin
      // Stage 1: capture the accepted tuple.
      r_s1_valid <= w_xfer;
      if (w_xfer) begin
        r_s1_exact  <= w_exact;
        r_s1_approx <= {in_if.appr_cout, in_if.appr_sum};
        r_accepted  <= r_accepted + CNT_W'(1);
        if (r_accepted + CNT_W'(1) == r_target) r_in_ready <= 1'b0;
      end

      // Stage 2: fold the distance into the statistics.
      if (r_s1_valid) begin
        r_sample_count <= r_sample_count + CNT_W'(1);
        if (w_ed != '0) r_err_count <= r_err_count + CNT_W'(1);
        if (w_ed > r_max_ed) r_max_ed <= w_ed;
        r_sum_ed  <= ACC_W'(sat_add(SAT_W'(r_sum_ed), SAT_W'(w_ed), ACC_W));
        r_last_ed <= w_ed;
      end

      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_target       <= n_samples;
            r_accepted     <= '0;
            r_sample_count <= '0;
            r_err_count    <= '0;
            r_max_ed       <= '0;
            r_sum_ed       <= '0;
            r_last_ed      <= '0;
            if (n_samples == '0) begin
              r_state    <= DONE;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_in_ready <= 1'b0;
            end else begin
              r_state    <= RUN;
              r_busy     <= 1'b1;
              r_done     <= 1'b0;
              r_in_ready <= 1'b1;
            end
          end
        end
        RUN: begin
          // The final sample is in stage 1 once all targets are accepted;
          // leave RUN on the edge that accumulates it.
          if (r_s1_valid && (r_accepted == r_target)) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign sample_count = r_sample_count;
  assign err_count    = r_err_count;
  assign max_ed       = r_max_ed;
  assign sum_ed       = r_sum_ed;
  assign last_ed      = r_last_ed;

endmodule

// File: tb/tb_ama_error_monitor.sv
// -----------------------------------------------------------------------------
// tb_ama_error_monitor
// Directed bench for ama_error_monitor (WIDTH=24, CNT_W=32, ACC_W=8 so the
// saturating accumulator can be driven to its limit). Single-sample runs come
// from a vector table; multi-sample runs, ignored start, n_samples=0 and
// clear-during-run are hand-written sequences. Define AMA_MON_SQERR_EN to
// also check sum_sq_ed.
// -----------------------------------------------------------------------------
module tb_ama_error_monitor;

  localparam int WIDTH = 24;
  localparam int CNT_W = 32;
  localparam int ACC_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             clear;
  logic [CNT_W-1:0] n_samples;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sample_count;
  logic [CNT_W-1:0] err_count;
  logic [WIDTH:0]   max_ed;
  logic [ACC_W-1:0] sum_ed;
  logic [WIDTH:0]   last_ed;
`ifdef AMA_MON_SQERR_EN
  logic [2*WIDTH+17:0] sum_sq_ed;
`endif

  ama_error_monitor_if #(.WIDTH(WIDTH)) mif ();

  ama_error_monitor #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W),
    .ACC_W (ACC_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .clear        (clear),
    .n_samples    (n_samples),
    .in_if        (mif),
    .busy         (busy),
    .done         (done),
    .sample_count (sample_count),
    .err_count    (err_count),
    .max_ed       (max_ed),
    .sum_ed       (sum_ed),
    .last_ed      (last_ed)
`ifdef AMA_MON_SQERR_EN
    ,
    .sum_sq_ed    (sum_sq_ed)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH:0]   appr;     // {appr_cout, appr_sum}
    logic [WIDTH:0]   ed;       // expected error distance
    logic [ACC_W-1:0] sum;      // expected sum_ed after a one-sample run
  } vec_t;

  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; presents one tuple for exactly one accepting edge
  // and returns at the following negedge.
  task automatic push(input vec_t v);
    int waited = 0;
    while (!mif.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("push_ready", mif.in_ready, 1'b1);
    mif.in_valid  = 1'b1;
    mif.a         = v.a;
    mif.b         = v.b;
    mif.cin       = v.cin;
    mif.appr_sum  = v.appr[WIDTH-1:0];
    mif.appr_cout = v.appr[WIDTH];
    @(negedge clk);
    mif.in_valid  = 1'b0;
  endtask

  task automatic start_run(input logic [CNT_W-1:0] n);
    start     = 1'b1;
    n_samples = n;
    @(negedge clk);
    start     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{24'h135FAD, 24'h8D683D, 1'b1, 25'h0A0C7EB, 25'h0000000, 8'h00};
    vecs[1] = '{24'hBAAC2A, 24'h4EF295, 1'b0, 25'h1099EB0, 25'h000000F, 8'h0F};
    vecs[2] = '{24'h1E6D76, 24'h006F80, 1'b0, 25'h01EDCF0, 25'h0000006, 8'h06};
    vecs[3] = '{24'hFFFFFF, 24'hFFFFFF, 1'b1, 25'h0000000, 25'h1FFFFFF, 8'hFF};
    vecs[4] = '{24'h000000, 24'h000000, 1'b0, 25'h1FFFFFF, 25'h1FFFFFF, 8'hFF};
    vecs[5] = '{24'h000010, 24'h000000, 1'b0, 25'h0000074, 25'h0000064, 8'h64};
    vecs[6] = '{24'h800000, 24'h800000, 1'b0, 25'h1000000, 25'h0000000, 8'h00};

    rst_n = 1'b0; start = 1'b0; clear = 1'b0; n_samples = '0;
    mif.in_valid = 1'b0; mif.a = '0; mif.b = '0; mif.cin = 1'b0;
    mif.appr_sum = '0; mif.appr_cout = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_in_ready", mif.in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sample_count", sample_count, 0);
    check("rst_err_count", err_count, 0);
    check("rst_max_ed", max_ed, 0);
    check("rst_sum_ed", sum_ed, 0);
    check("rst_last_ed", last_ed, 0);

    // Valid without start is never accepted.
    mif.in_valid = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_in_ready", mif.in_ready, 1'b0);
    check("idle_sample_count", sample_count, 0);
    mif.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_sample_count_drained", sample_count, 0);

    // Table: one-sample runs, each restarting from DONE.
    for (int i = 0; i < 7; i++) begin
      start_run(1);
      check($sformatf("v%0d_started_ready", i), mif.in_ready, 1'b1);
      check($sformatf("v%0d_started_busy", i), busy, 1'b1);
      check($sformatf("v%0d_started_sum", i), sum_ed, 0);
      check($sformatf("v%0d_started_count", i), sample_count, 0);
      push(vecs[i]);
      check($sformatf("v%0d_ready_low", i), mif.in_ready, 1'b0);
      check($sformatf("v%0d_done_early", i), done, 1'b0);
      @(negedge clk);
      check($sformatf("v%0d_done", i), done, 1'b1);
      check($sformatf("v%0d_busy", i), busy, 1'b0);
      check($sformatf("v%0d_sample_count", i), sample_count, 1);
      check($sformatf("v%0d_err_count", i), err_count, (vecs[i].ed != '0) ? 1 : 0);
      check($sformatf("v%0d_last_ed", i), last_ed, vecs[i].ed);
      check($sformatf("v%0d_max_ed", i), max_ed, vecs[i].ed);
      check($sformatf("v%0d_sum_ed", i), sum_ed, vecs[i].sum);
    end

    // Two-sample run; a start pulse mid-run (asking for 5) must be ignored.
    start_run(2);
    push(vecs[1]);
    start = 1'b1;
    n_samples = 5;
    push(vecs[2]);
    start = 1'b0;
    check("two_mid_count", sample_count, 1);
    check("two_mid_done", done, 1'b0);
    check("two_mid_busy", busy, 1'b1);
    @(negedge clk);
    check("two_done", done, 1'b1);
    check("two_sample_count", sample_count, 2);
    check("two_err_count", err_count, 2);
    check("two_max_ed", max_ed, 25'hF);
    check("two_sum_ed", sum_ed, 8'h15);
    check("two_last_ed", last_ed, 25'h6);
`ifdef AMA_MON_SQERR_EN
    check("two_sum_sq_ed", sum_sq_ed, 'h105);
`endif
    repeat (2) @(negedge clk);
    check("two_held_count", sample_count, 2);
    check("two_held_ready", mif.in_ready, 1'b0);

    // Saturation: three samples with ed=0x64 (both difference directions).
    start_run(3);
    push(vecs[5]);
    push('{24'h000100, 24'h000000, 1'b0, 25'h000009C, 25'h0000064, 8'h00});
    push(vecs[5]);
    @(negedge clk);
    check("sat_done", done, 1'b1);
    check("sat_sample_count", sample_count, 3);
    check("sat_err_count", err_count, 3);
    check("sat_max_ed", max_ed, 25'h64);
    check("sat_sum_ed", sum_ed, 8'hFF);
`ifdef AMA_MON_SQERR_EN
    check("sat_sum_sq_ed", sum_sq_ed, 'h7530);
`endif

    // n_samples = 0 goes straight to DONE with cleared statistics.
    start_run(0);
    check("zero_done", done, 1'b1);
    check("zero_busy", busy, 1'b0);
    check("zero_in_ready", mif.in_ready, 1'b0);
    check("zero_sample_count", sample_count, 0);
    check("zero_max_ed", max_ed, 0);
    check("zero_sum_ed", sum_ed, 0);
    check("zero_last_ed", last_ed, 0);

    // clear together with start mid-run: abort to IDLE, drop stage-1 sample.
    start_run(3);
    push(vecs[1]);
    push(vecs[2]);
    check("clr_pre_count", sample_count, 1);
    check("clr_pre_sum", sum_ed, 8'h0F);
    clear = 1'b1;
    start = 1'b1;
    n_samples = 3;
    @(negedge clk);
    clear = 1'b0;
    start = 1'b0;
    check("clr_busy", busy, 1'b0);
    check("clr_done", done, 1'b0);
    check("clr_in_ready", mif.in_ready, 1'b0);
    check("clr_sample_count", sample_count, 0);
    check("clr_err_count", err_count, 0);
    check("clr_max_ed", max_ed, 0);
    check("clr_sum_ed", sum_ed, 0);
    check("clr_last_ed", last_ed, 0);
    mif.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    mif.in_valid = 1'b0;
    check("clr_after_count", sample_count, 0);
    check("clr_after_ready", mif.in_ready, 1'b0);

    // Recovery after clear.
    start_run(1);
    push(vecs[2]);
    @(negedge clk);
    check("rec_done", done, 1'b1);
    check("rec_sum_ed", sum_ed, 8'h06);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
